// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one operation at a time to an external combinational
// ALU. Registers the operands and the decoded ALU code, waits a fixed number of
// settle cycles, captures the result, and holds it until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// 1. valid, once raised by the block (rsp_valid), is held with stable payload
// until that transfer edge; req_ready never depends on req_valid.
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_ALUOp,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_A,
    input  logic [31:0] req_B,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [3:0]  ALU_Opt,
    input  logic [31:0] ALU_Res,
    input  logic        Zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_Res,
    output logic        rsp_Zero,
    output logic        rsp_Illegal
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Out-of-range settle values fall back to a single settle cycle.
    localparam int SETTLE_EFF = (SETTLE_CYCLES >= 1 && SETTLE_CYCLES <= 15) ? SETTLE_CYCLES : 1;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_EFF - 1);

    localparam logic [3:0] OPT_AND = 4'b0000;
    localparam logic [3:0] OPT_OR  = 4'b0001;
    localparam logic [3:0] OPT_ADD = 4'b0010;
    localparam logic [3:0] OPT_SUB = 4'b0110;
    localparam logic [3:0] OPT_SLT = 4'b0111;
    localparam logic [3:0] OPT_NOR = 4'b1100;
    localparam logic [3:0] OPT_ILL = 4'b1111;

    logic [1:0] state;
    logic [3:0] settle_cnt;
    logic [3:0] dec_opt;
    logic       dec_illegal;
    logic       accept;

    // Ready only while idle and out of reset; response valid only while responding.
    assign req_ready = rst_n && (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;

    // Decode the operation class and funct field into the ALU control code.
    always_comb begin
        dec_opt     = OPT_ILL;
        dec_illegal = 1'b1;
        case (req_ALUOp)
            2'b00: begin dec_opt = OPT_ADD; dec_illegal = 1'b0; end
            2'b01: begin dec_opt = OPT_SUB; dec_illegal = 1'b0; end
            2'b10: begin
                dec_illegal = 1'b0;
                case (req_funct)
                    6'b100100: dec_opt = OPT_AND;
                    6'b100101: dec_opt = OPT_OR;
                    6'b100000: dec_opt = OPT_ADD;
                    6'b100010: dec_opt = OPT_SUB;
                    6'b101010: dec_opt = OPT_SLT;
                    6'b100111: dec_opt = OPT_NOR;
                    default: begin
                        dec_opt     = OPT_ILL;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: begin dec_opt = OPT_ILL; dec_illegal = 1'b1; end
        endcase
    end

    // Operand and opcode registers feeding the ALU; they change only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SrcA    <= '0;
            SrcB    <= '0;
            ALU_Opt <= '0;
        end else if (accept) begin
            SrcA    <= req_A;
            SrcB    <= req_B;
            ALU_Opt <= dec_opt;
        end
    end

    // Sequencing: idle -> settle wait -> respond; illegal requests skip the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (dec_illegal) begin
                            state <= ST_RESP;
                        end else begin
                            state      <= ST_WAIT;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response payload: cleared marker for illegal requests, ALU capture after settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_Res     <= '0;
            rsp_Zero    <= 1'b0;
            rsp_Illegal <= 1'b0;
        end else if (state == ST_IDLE && accept && dec_illegal) begin
            rsp_Res     <= '0;
            rsp_Zero    <= 1'b0;
            rsp_Illegal <= 1'b1;
        end else if (state == ST_WAIT && settle_cnt == 4'd0) begin
            rsp_Res     <= ALU_Res;
            rsp_Zero    <= Zero;
            rsp_Illegal <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 1, the number of cycles (legal range 1..15) that the ALU outputs get to settle before capture.
REQ-002 The block SHALL have these ports, one per line:
 clk  in  1  the only clock; all state changes on its rising edge.
 rst_n  in  1  reset; asynchronous, active-low.
 req_valid  in  1  the request is valid.
 req_ready  out  1  the block can accept a request.
 req_ALUOp  in  2  operation class: 00 = add, 01 = sub, 10 = decode by funct, 11 = reserved.
 req_funct  in  6  R-type funct field; used only when req_ALUOp = 10.
 req_A  in  32  first operand.
 req_B  in  32  second operand.
 SrcA  out  32  registered operand A driven to the ALU.
 SrcB  out  32  registered operand B driven to the ALU.
 ALU_Opt  out  4  registered ALU operation code.
 ALU_Res  in  32  ALU result; combinational from SrcA, SrcB and ALU_Opt.
 Zero  in  1  ALU zero flag.
 rsp_valid  out  1  the response is valid.
 rsp_ready  in  1  the consumer accepts the response.
 rsp_Res  out  32  captured result.
 rsp_Zero  out  1  captured zero flag.
 rsp_Illegal  out  1  the request did not decode to a legal operation.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE with rst_n high; rsp_valid SHALL be 1 only in RESP.
REQ-005 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-006 On acceptance, SrcA SHALL load req_A, SrcB SHALL load req_B and ALU_Opt SHALL load the decoded code.
REQ-007 Decode, req_ALUOp 00 SHALL give 0010 (ADD) and 01 SHALL give 0110 (SUB).
REQ-008 Decode, req_ALUOp 10 SHALL map funct 100100 to 0000 (AND), 100101 to 0001 (OR), 100000 to 0010 (ADD), 100010 to 0110 (SUB), 101010 to 0111 (SLT) and 100111 to 1100 (NOR).
REQ-009 Any other funct with req_ALUOp 10, and req_ALUOp 11, SHALL be illegal, and ALU_Opt SHALL load 1111.
REQ-010 On a legal acceptance the FSM SHALL go IDLE->WAIT and load a 4-bit settle counter with SETTLE_CYCLES-1.
REQ-011 In WAIT the counter SHALL decrement each cycle while nonzero.
REQ-012 On the WAIT edge where the counter is 0, the block SHALL capture ALU_Res into rsp_Res and Zero into rsp_Zero, clear rsp_Illegal, and go to RESP.
REQ-013 On an illegal acceptance the FSM SHALL go IDLE->RESP directly with rsp_Res = 0, rsp_Zero = 0 and rsp_Illegal = 1.
REQ-014 Legal latency SHALL be exactly SETTLE_CYCLES+1 edges from the accept edge to the first cycle with rsp_valid = 1; illegal latency SHALL be 1 edge.
REQ-015 In RESP, rsp_Res, rsp_Zero and rsp_Illegal SHALL hold stable until the edge where rsp_ready = 1, and the FSM SHALL then go RESP->IDLE.
REQ-016 A request and a response SHALL never complete on the same edge; minimum spacing between accepts SHALL be SETTLE_CYCLES+2 cycles for legal requests and 2 cycles for illegal ones.
REQ-017 SrcA, SrcB and ALU_Opt SHALL hold their values from acceptance until the next acceptance.
REQ-018 req_* inputs SHALL be ignored outside IDLE; ALU_Res and Zero SHALL be ignored except on the capture edge.
REQ-019 A SETTLE_CYCLES value outside 1..15 SHALL be treated as 1.

Reset
REQ-020 While rst_n = 0, the block SHALL immediately (asynchronously) set state = IDLE, req_ready = 0, rsp_valid = 0, SrcA = SrcB = 0, ALU_Opt = 0000, rsp_Res = 0, rsp_Zero = 0, rsp_Illegal = 0 and counter = 0.
REQ-021 Reset asserted in WAIT or RESP SHALL abort the operation with no response issued; req_ready SHALL rise in the first cycle after rst_n = 1.

Verification
REQ-022 Legal add: SETTLE_CYCLES = 1, ALUOp 10, funct 100000, A = 5, B = 7, rsp_ready = 1 -> ALU_Opt = 0010; rsp_valid is 1 two edges after accept with rsp_Res = 12, rsp_Zero = 0, rsp_Illegal = 0.
REQ-023 Branch compare: ALUOp 01, A = B = 0x1234 -> ALU_Opt = 0110, rsp_Res = 0, rsp_Zero = 1.
REQ-024 Illegal op: ALUOp 10, funct 000000 -> ALU_Opt = 1111; rsp_valid is 1 one edge after accept with rsp_Illegal = 1 and rsp_Res = 0.
REQ-025 Backpressure: SLT with A = 3, B = 9, rsp_ready held 0 for 5 cycles -> rsp_valid = 1 and rsp_Res = 1 stay stable, req_ready = 0 throughout, and IDLE is entered one edge after rsp_ready = 1.
REQ-026 Reset mid-op: SETTLE_CYCLES = 4, assert rst_n = 0 in WAIT -> all outputs are 0 immediately, no rsp_valid pulse, and req_ready = 1 in the cycle after release.
REQ-027 Settle timing: SETTLE_CYCLES = 3 with a NOR of 0 and 0 -> capture on the 4th edge after accept, rsp_Res = 0xFFFFFFFF.
